// File: rtl/titan_pkg.sv
// rtl/titan_pkg.sv - shared types and constants for the SPI register sequencer
package titan_pkg;
   typedef enum logic [1:0] {FR_IDLE, FR_CMD, FR_WRITE, FR_READ} frame_state_t;
   typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_t;

   // Command bit 7 set selects a read; clear selects a write.
   localparam int CMD_RW_BIT = 7;

   localparam int ERR_TIMEOUT  = 0;
   localparam int ERR_OVERRUN  = 1;
   localparam int ERR_UNDERRUN = 2;

   localparam logic [7:0] TX_FILL = 8'hFF;
endpackage

// File: rtl/bus_req_timer.sv
// rtl/bus_req_timer.sv - req/ack handshake with a saturating timeout counter
module bus_req_timer import titan_pkg::*; #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic ack,
   output logic req,
   output logic done,
   output logic timeout
);
   localparam int CW = $clog2(TIMEOUT + 1);

   bus_state_t    state;
   logic [CW-1:0] cnt;

   assign req     = (state == BUS_BUSY);
   assign done    = req & ack;
   // The request is held for exactly TIMEOUT cycles when no ack arrives.
   assign timeout = req & ~ack & (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BUS_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            BUS_IDLE: if (start) begin
               state <= BUS_BUSY;
               cnt   <= '0;
            end
            BUS_BUSY: begin
               if (ack || cnt == CW'(TIMEOUT - 1))
                  state <= BUS_IDLE;
               else if (cnt != CW'(TIMEOUT))
                  cnt <= cnt + 1'b1;
            end
            default: state <= BUS_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - SPI frame decoder driving register-bus bursts
module spi_reg_sequencer import titan_pkg::*; #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int TIMEOUT  = 255,
   parameter int AUTO_INC = 1
) (
   input  logic              sys_clock_i,
   input  logic              sys_reset_ni,
   input  logic              frame_active_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_byte_i,
   input  logic              tx_ready_i,
   output logic [7:0]        tx_byte_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic [2:0]        err_o,
   input  logic              err_clear_i
);
   localparam int NB = DATA_W / 8;
   localparam int BW = $clog2(NB + 1);

   frame_state_t      state;
   logic [ADDR_W-1:0] addr, cmd_addr, addr_inc;
   logic [DATA_W-1:0] wr_shift, wr_word, tx_shift, tx_shift_d, pf_word, rd_word;
   logic [BW-1:0]     wr_cnt, tx_left, tx_left_d;
   logic              pf_valid, pf_take, rd_pending, rd_to_tx;
   logic              rx_take, word_full, start_wr, start_rd, next_is_read;
   logic              bus_done, bus_timeout, rd_arrive, underrun;
   logic [2:0]        err_evt;

   assign rx_take   = rx_valid_i & frame_active_i;
   assign cmd_addr  = ADDR_W'(rx_byte_i[6:0]);
   assign addr_inc  = addr + ADDR_W'(AUTO_INC);
   assign wr_word   = (wr_shift << 8) | DATA_W'(rx_byte_i);
   assign word_full = (state == FR_WRITE) & rx_take & (wr_cnt == BW'(NB - 1));
   assign start_wr  = word_full & ~bus_req_o;
   // Reads launch straight from the command byte, then refill whenever the prefetch slot is empty.
   assign start_rd  = ~bus_req_o & frame_active_i &
                      (((state == FR_CMD) & rx_valid_i & rx_byte_i[CMD_RW_BIT]) |
                       ((state == FR_READ) & ~rd_pending & ~pf_valid));
   assign next_is_read = frame_active_i &
                      ((state == FR_READ) | ((state == FR_CMD) & rx_valid_i & rx_byte_i[CMD_RW_BIT]));
   assign rd_arrive = rd_pending & (bus_done | bus_timeout);
   assign rd_word   = bus_done ? bus_rdata_i : '1;
   assign underrun  = (state == FR_READ) & frame_active_i & tx_ready_i & (tx_left == '0);

   assign err_evt[ERR_TIMEOUT]  = bus_timeout;
   assign err_evt[ERR_OVERRUN]  = word_full & bus_req_o;
   assign err_evt[ERR_UNDERRUN] = underrun;

   bus_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (sys_clock_i),
      .rst_n   (sys_reset_ni),
      .start   (start_rd | start_wr),
      .ack     (bus_ack_i),
      .req     (bus_req_o),
      .done    (bus_done),
      .timeout (bus_timeout)
   );

   always_comb begin
      tx_shift_d = tx_shift;
      tx_left_d  = tx_left;
      pf_take    = 1'b0;
      rd_to_tx   = 1'b0;
      if (state == FR_READ && frame_active_i) begin
         if (tx_ready_i && tx_left != '0) begin
            if (tx_left != BW'(1)) begin
               tx_shift_d = tx_shift << 8;
               tx_left_d  = tx_left - 1'b1;
            end else if (pf_valid) begin
               tx_shift_d = pf_word;
               tx_left_d  = BW'(NB);
               pf_take    = 1'b1;
            end else begin
               tx_left_d = '0;
            end
         end
         if (rd_arrive && tx_left_d == '0) begin
            tx_shift_d = rd_word;
            tx_left_d  = BW'(NB);
            rd_to_tx   = 1'b1;
         end
      end else begin
         tx_left_d = '0;
      end
   end

   always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
      if (!sys_reset_ni) begin
         state       <= FR_IDLE;
         addr        <= '0;
         wr_shift    <= '0;
         wr_cnt      <= '0;
         tx_shift    <= '0;
         tx_left     <= '0;
         pf_word     <= '0;
         pf_valid    <= 1'b0;
         rd_pending  <= 1'b0;
         tx_byte_o   <= 8'h00;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         err_o       <= '0;
      end else begin
         tx_shift  <= tx_shift_d;
         tx_left   <= tx_left_d;
         tx_byte_o <= next_is_read ? ((tx_left_d != '0) ? tx_shift_d[DATA_W-1 -: 8] : TX_FILL) : 8'h00;
         err_o     <= (err_clear_i ? 3'b000 : err_o) | err_evt;

         if (start_wr || start_rd) begin
            bus_we_o    <= start_wr;
            bus_addr_o  <= (state == FR_CMD) ? cmd_addr : addr;
            bus_wdata_o <= start_wr ? wr_word : '0;
         end
         if (start_rd)
            rd_pending <= 1'b1;
         else if (rd_arrive)
            rd_pending <= 1'b0;
         if (pf_take)
            pf_valid <= 1'b0;
         if (rd_arrive && !rd_to_tx) begin
            pf_word  <= rd_word;
            pf_valid <= 1'b1;
         end

         // Frame end wins over everything above; an in-flight request finishes unobserved.
         if (!frame_active_i) begin
            state      <= FR_IDLE;
            wr_cnt     <= '0;
            pf_valid   <= 1'b0;
            rd_pending <= 1'b0;
         end else begin
            case (state)
               FR_IDLE: state <= FR_CMD;
               FR_CMD: if (rx_valid_i) begin
                  addr   <= cmd_addr;
                  wr_cnt <= '0;
                  state  <= rx_byte_i[CMD_RW_BIT] ? FR_READ : FR_WRITE;
               end
               FR_WRITE: if (rx_valid_i) begin
                  wr_shift <= wr_word;
                  if (word_full) begin
                     wr_cnt <= '0;
                     addr   <= addr_inc;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
               FR_READ: if (rd_arrive) addr <= addr_inc;
               default: state <= FR_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb/tb_spi_reg_sequencer.sv - randomized self-checking bench for spi_reg_sequencer
module tb_spi_reg_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, frame_active, rx_valid, tx_ready, err_clear;
   logic [7:0]  rx_byte, tx_byte;
   logic        bus_req, bus_we, bus_ack, resp_ack, late_ack;
   logic [6:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic [2:0]  err;

   typedef struct packed {logic we; logic [6:0] addr; logic [31:0] data;} txn_t;
   txn_t        txq[$];
   logic [31:0] mem [128];
   logic        ack_hold;
   int          ack_delay;
   int          checks = 0;
   int          errors = 0;

   assign bus_ack = resp_ack | late_ack;
   always #5 clk = ~clk;

   spi_reg_sequencer dut (
      .sys_clock_i(clk), .sys_reset_ni(rst_n), .frame_active_i(frame_active),
      .rx_valid_i(rx_valid), .rx_byte_i(rx_byte), .tx_ready_i(tx_ready), .tx_byte_o(tx_byte),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .err_o(err), .err_clear_i(err_clear)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output logic req_after);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick(1);
      req_after = bus_req;
      rx_valid = 1'b0;
      tick(gap);
   endtask

   task automatic pull(output logic [7:0] b);
      b = tx_byte;
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      tick(2);
   endtask

   task automatic frame_on();
      frame_active = 1'b1;
      tick(2);
   endtask

   task automatic frame_off();
      frame_active = 1'b0;
      tick(3);
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!bus_req) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic clear_err();
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      check_eq("err_cleared", 32'(err), 32'd0);
   endtask

   // Bus slave: acks after ack_delay request cycles, returns mem[addr] as read data.
   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      resp_ack  = 1'b0;
      bus_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         resp_ack = 1'b0;
         if (bus_req && !ack_hold) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               resp_ack  = 1'b1;
               bus_rdata = mem[bus_addr];
               wait_cnt  = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      logic req_q;
      req_q = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus_req && !req_q) txq.push_back({bus_we, bus_addr, bus_wdata});
         req_q = bus_req;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic        ra, ok;
      logic [7:0]  b;
      logic [31:0] w [4];
      logic [31:0] word;
      logic [7:0]  exp8 [8];
      int          base, n, a, cnt;

      rst_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
      tx_ready = 1'b0; err_clear = 1'b0; late_ack = 1'b0; ack_hold = 1'b0; ack_delay = 1;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      tick(2);
      check_eq("rst_tx", 32'(tx_byte), 32'h00);
      check_eq("rst_req", 32'(bus_req), 32'd0);
      check_eq("rst_we", 32'(bus_we), 32'd0);
      check_eq("rst_addr", 32'(bus_addr), 32'd0);
      check_eq("rst_wdata", bus_wdata, 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single-word write, ack in the third request cycle.
      ack_delay = 3;
      base = txq.size();
      frame_on();
      send_byte(8'h05, 2, ra);
      send_byte(8'h11, 2, ra);
      send_byte(8'h22, 2, ra);
      send_byte(8'h33, 2, ra);
      send_byte(8'h44, 0, ra);
      check_eq("wr_latency", 32'(ra), 32'd1);
      check_eq("wr_tx_zero", 32'(tx_byte), 32'h00);
      tick(6);
      frame_off();
      check_eq("wr_count", 32'(txq.size() - base), 32'd1);
      if (txq.size() > base) begin
         check_eq("wr_we", 32'(txq[base].we), 32'd1);
         check_eq("wr_addr", 32'(txq[base].addr), 32'd5);
         check_eq("wr_data", txq[base].data, 32'h11223344);
      end

      // Two-word read burst from address 2.
      ack_delay = 2;
      mem[2] = 32'hA1B2C3D4;
      mem[3] = 32'h01020304;
      exp8 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
      base = txq.size();
      frame_on();
      send_byte(8'h82, 0, ra);
      check_eq("rd_latency", 32'(ra), 32'd1);
      tick(10);
      for (int k = 0; k < 8; k++) begin
         pull(b);
         check_eq("rd_burst_byte", 32'(b), 32'(exp8[k]));
      end
      frame_off();
      wait_idle(ok);
      check_eq("rd_burst_idle", 32'(ok), 32'd1);
      check_eq("rd_burst_reqs", 32'(txq.size() - base >= 2), 32'd1);
      if (txq.size() >= base + 2) begin
         check_eq("rd_burst_addr0", 32'(txq[base].addr), 32'd2);
         check_eq("rd_burst_addr1", 32'(txq[base + 1].addr), 32'd3);
         check_eq("rd_burst_we", 32'(txq[base].we | txq[base + 1].we), 32'd0);
      end
      check_eq("rd_burst_err", 32'(err), 32'd0);

      // Randomized write and read bursts; the first two wrap the address at 7F.
      for (int it = 0; it < 8; it++) begin
         a = (it < 2) ? 127 : $urandom_range(0, 127);
         n = (it < 2) ? 2 : $urandom_range(1, 3);
         ack_delay = $urandom_range(1, 4);
         base = txq.size();
         frame_on();
         if (it == 0 || (it != 1 && $urandom_range(0, 1) == 0)) begin
            send_byte(8'(a), 2, ra);
            for (int k = 0; k < n; k++) begin
               w[k] = $urandom;
               for (int j = 3; j >= 0; j--) send_byte(w[k][8*j +: 8], 2, ra);
            end
            frame_off();
            wait_idle(ok);
            check_eq("rw_idle", 32'(ok), 32'd1);
            check_eq("rw_count", 32'(txq.size() - base), 32'(n));
            for (int k = 0; k < n; k++) begin
               if (base + k < txq.size()) begin
                  check_eq("rw_we", 32'(txq[base + k].we), 32'd1);
                  check_eq("rw_addr", 32'(txq[base + k].addr), 32'((a + k) % 128));
                  check_eq("rw_data", txq[base + k].data, w[k]);
               end
            end
         end else begin
            send_byte(8'h80 | 8'(a), 0, ra);
            check_eq("rr_latency", 32'(ra), 32'd1);
            tick(10);
            for (int k = 0; k < 4 * n; k++) begin
               pull(b);
               word = mem[(a + k / 4) % 128];
               check_eq("rr_byte", 32'(b), 32'(word[8*(3 - k % 4) +: 8]));
            end
            frame_off();
            wait_idle(ok);
            check_eq("rr_idle", 32'(ok), 32'd1);
            check_eq("rr_reqs", 32'(txq.size() - base >= n), 32'd1);
            for (int k = 0; k < n; k++) begin
               if (base + k < txq.size()) begin
                  check_eq("rr_we", 32'(txq[base + k].we), 32'd0);
                  check_eq("rr_addr", 32'(txq[base + k].addr), 32'((a + k) % 128));
               end
            end
         end
         check_eq("rand_err", 32'(err), 32'd0);
      end

      // Read timeout: request held 255 cycles, word reads as all ones, late ack ignored.
      ack_delay = 1;
      ack_hold = 1'b1;
      frame_on();
      send_byte(8'h80 | 8'h10, 0, ra);
      cnt = 0;
      while (bus_req && cnt < 400) begin
         cnt++;
         tick(1);
      end
      check_eq("to_len", 32'(cnt), 32'd255);
      check_eq("to_err", 32'(err), 32'b001);
      late_ack = 1'b1;
      tick(1);
      late_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pull(b);
         check_eq("to_fill_byte", 32'(b), 32'hFF);
      end
      check_eq("to_err_after", 32'(err), 32'b001);
      ack_hold = 1'b0;
      frame_off();
      wait_idle(ok);
      check_eq("to_idle", 32'(ok), 32'd1);
      clear_err();

      // Underrun: tx_ready before any read word has returned.
      ack_hold = 1'b1;
      frame_on();
      send_byte(8'h80 | 8'h20, 2, ra);
      pull(b);
      check_eq("ur_byte", 32'(b), 32'hFF);
      check_eq("ur_err", 32'(err), 32'b100);
      ack_hold = 1'b0;
      frame_off();
      wait_idle(ok);
      clear_err();

      // Overrun: second word completes while the first is still unacknowledged.
      ack_hold = 1'b1;
      a = $urandom_range(0, 127);
      base = txq.size();
      frame_on();
      send_byte(8'(a), 2, ra);
      for (int k = 0; k < 2; k++) begin
         w[k] = $urandom;
         for (int j = 3; j >= 0; j--) send_byte(w[k][8*j +: 8], 2, ra);
      end
      tick(15);
      ack_hold = 1'b0;
      wait_idle(ok);
      frame_off();
      check_eq("ov_count", 32'(txq.size() - base), 32'd1);
      if (txq.size() > base) begin
         check_eq("ov_addr", 32'(txq[base].addr), 32'(a));
         check_eq("ov_data", txq[base].data, w[0]);
      end
      check_eq("ov_err", 32'(err), 32'b010);
      clear_err();

      // Chip-select abort mid-word, then a normal frame.
      base = txq.size();
      frame_on();
      send_byte(8'h07, 2, ra);
      send_byte(8'hDE, 2, ra);
      send_byte(8'hAD, 2, ra);
      frame_off();
      check_eq("abort_noreq", 32'(txq.size() - base), 32'd0);
      check_eq("abort_tx", 32'(tx_byte), 32'h00);
      frame_on();
      send_byte(8'h09, 2, ra);
      w[0] = $urandom;
      for (int j = 3; j >= 0; j--) send_byte(w[0][8*j +: 8], 2, ra);
      frame_off();
      wait_idle(ok);
      check_eq("abort_next_count", 32'(txq.size() - base), 32'd1);
      if (txq.size() > base) begin
         check_eq("abort_next_addr", 32'(txq[base].addr), 32'd9);
         check_eq("abort_next_data", txq[base].data, w[0]);
      end

      // Asynchronous reset while a read request is outstanding.
      ack_hold = 1'b1;
      frame_on();
      send_byte(8'hB3, 0, ra);
      tick(3);
      check_eq("mid_req_before", 32'(bus_req), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_req", 32'(bus_req), 32'd0);
      check_eq("mid_rst_addr", 32'(bus_addr), 32'd0);
      check_eq("mid_rst_we", 32'(bus_we), 32'd0);
      check_eq("mid_rst_tx", 32'(tx_byte), 32'h00);
      check_eq("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      frame_active = 1'b0;
      ack_hold = 1'b0;
      rst_n = 1'b1;
      tick(3);
      check_eq("post_rst_req", 32'(bus_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
